// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - round-robin arbiter sharing one register file between two requesters
module rf_port_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [2:0]        op0,
  input  logic [2:0]        op1,
  input  logic [ADDR_W-1:0] ra1_0,
  input  logic [ADDR_W-1:0] ra1_1,
  input  logic [ADDR_W-1:0] ra2_0,
  input  logic [ADDR_W-1:0] ra2_1,
  input  logic [ADDR_W-1:0] wa_0,
  input  logic [ADDR_W-1:0] wa_1,
  input  logic [DATA_W-1:0] wd_0,
  input  logic [DATA_W-1:0] wd_1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic [2:0]        rf_valid_bits,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  input  logic              rf_out_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               owner_q;   // requester being served
  logic               last_q;    // requester granted most recently
  logic [2:0]         op_q;      // {rd1_en, rd2_en, wr_en} of the transaction in flight
  logic [ADDR_W-1:0]  wa_q;
  logic [DATA_W-1:0]  wd_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               any_req;
  logic               win;
  logic [2:0]         win_op;
  logic [ADDR_W-1:0]  win_ra1;
  logic [ADDR_W-1:0]  win_ra2;
  logic [ADDR_W-1:0]  win_wa;
  logic [DATA_W-1:0]  win_wd;

  // Pick the winner: a lone request wins, a tie goes to whoever was not granted last.
  always_comb begin
    any_req = req0 | req1;
    win     = (req0 && req1) ? ~last_q : req1;
    win_op  = win ? op1   : op0;
    win_ra1 = win ? ra1_1 : ra1_0;
    win_ra2 = win ? ra2_1 : ra2_0;
    win_wa  = win ? wa_1  : wa_0;
    win_wd  = win ? wd_1  : wd_0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: reads first, then the optional write, then a single done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (win_op[2] | win_op[1]) begin
            state_d = READ;
          end else if (win_op[0]) begin
            state_d = WRITE;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        if (rf_out_valid) begin
          state_d = op_q[0] ? WRITE : DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and completion flags decode straight from the state; a write to r0 never strobes.
  always_comb begin
    rf_valid_bits = 3'b000;
    done0         = 1'b0;
    done1         = 1'b0;
    case (state_q)
      READ:    rf_valid_bits = {op_q[2], op_q[1], 1'b0};
      WRITE:   rf_valid_bits = {2'b00, |wa_q};
      default: rf_valid_bits = 3'b000;
    endcase
    if (state_q == DONE) begin
      done0 = ~owner_q;
      done1 = owner_q;
    end
    err0 = done0 & err_q;
    err1 = done1 & err_q;
  end

  // Transaction latch, timeout counter, read capture and register-file address/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      op_q         <= '0;
      wa_q         <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rdata1       <= '0;
      rdata2       <= '0;
      rf_read_reg1 <= '0;
      rf_read_reg2 <= '0;
      rf_write_reg <= '0;
      rf_data      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= win;
            last_q  <= win;
            op_q    <= win_op;
            wa_q    <= win_wa;
            wd_q    <= win_wd;
            err_q   <= (win_op == 3'b000);
            if (win_op[2] | win_op[1]) begin
              rf_read_reg1 <= win_ra1;
              rf_read_reg2 <= win_ra2;
            end else if (win_op[0]) begin
              rf_write_reg <= win_wa;
              rf_data      <= win_wd;
            end
          end
        end
        READ: cnt_q <= '0;
        WAIT: begin
          if (rf_out_valid) begin
            rdata1 <= op_q[2] ? rf_out1 : '0;
            rdata2 <= op_q[1] ? rf_out2 : '0;
            if (op_q[0]) begin
              rf_write_reg <= wa_q;
              rf_data      <= wd_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              err_q  <= 1'b1;
              rdata1 <= '0;
              rdata2 <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - self-checking bench for rf_port_arbiter
module tb_rf_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int TO = 4;
  localparam int NS = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [2:0]    op0 = '0, op1 = '0;
  logic [AW-1:0] ra1_0 = '0, ra1_1 = '0, ra2_0 = '0, ra2_1 = '0, wa_0 = '0, wa_1 = '0;
  logic [DW-1:0] wd_0 = '0, wd_1 = '0;
  logic          done0, done1, err0, err1;
  logic [DW-1:0] rdata1, rdata2, rf_data;
  logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [2:0]    rf_valid_bits;
  logic [DW-1:0] rf_out1 = '0, rf_out2 = '0;
  logic          rf_out_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // responder settings snapshotted by the model at grant time
  int            resp_delay = 0;
  logic [DW-1:0] resp_d1 = '0, resp_d2 = '0;

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .ra1_0(ra1_0), .ra1_1(ra1_1), .ra2_0(ra2_0), .ra2_1(ra2_1),
    .wa_0(wa_0), .wa_1(wa_1), .wd_0(wd_0), .wd_1(wd_1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata1(rdata1), .rdata2(rdata2),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2), .rf_write_reg(rf_write_reg),
    .rf_data(rf_data), .rf_valid_bits(rf_valid_bits),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .rf_out_valid(rf_out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Expected timeline, one entry per cycle (slot = value of cyc while the state is stable).
  logic [2:0]    e_vb      [NS];
  logic [1:0]    e_done    [NS];
  logic          e_err     [NS];
  logic          e_rd_chk  [NS];
  logic [AW-1:0] e_ra1     [NS];
  logic [AW-1:0] e_ra2     [NS];
  logic          e_wr_chk  [NS];
  logic [AW-1:0] e_wa      [NS];
  logic [DW-1:0] e_wd      [NS];
  logic          e_vin     [NS];
  logic [DW-1:0] e_o1      [NS];
  logic [DW-1:0] e_o2      [NS];
  logic          e_set_rd  [NS];
  logic [DW-1:0] e_rd1v    [NS];
  logic [DW-1:0] e_rd2v    [NS];

  task automatic clear_slot(input int k);
    e_vb[k] = '0; e_done[k] = '0; e_err[k] = 1'b0; e_rd_chk[k] = 1'b0; e_ra1[k] = '0;
    e_ra2[k] = '0; e_wr_chk[k] = 1'b0; e_wa[k] = '0; e_wd[k] = '0; e_vin[k] = 1'b0;
    e_o1[k] = '0; e_o2[k] = '0; e_set_rd[k] = 1'b0; e_rd1v[k] = '0; e_rd2v[k] = '0;
  endtask

  // Model + compare process: builds each transaction's timeline at grant, checks every cycle.
  initial begin
    int            s, free, m_last, w, t, d;
    logic [2:0]    o;
    logic [AW-1:0] a1, a2, wa;
    logic [DW-1:0] wd, m_rd1, m_rd2;
    bit            er;
    free = 0; m_last = 1; m_rd1 = '0; m_rd2 = '0;
    for (int k = 0; k < NS; k++) clear_slot(k);
    forever begin
      @(negedge clk);
      s = cyc;
      if (s > 0 && s < NS - 32) begin
        if (e_set_rd[s]) begin
          m_rd1 = e_rd1v[s];
          m_rd2 = e_rd2v[s];
        end
        chk("valid_bits", rf_valid_bits, e_vb[s]);
        chk("done", {done1, done0}, e_done[s]);
        chk("err", {err1, err0}, e_done[s] & {2{e_err[s]}});
        chk("rdata1", rdata1, m_rd1);
        chk("rdata2", rdata2, m_rd2);
        if (e_rd_chk[s]) begin
          chk("rd_addr1", rf_read_reg1, e_ra1[s]);
          chk("rd_addr2", rf_read_reg2, e_ra2[s]);
        end
        if (e_wr_chk[s]) begin
          chk("wr_addr", rf_write_reg, e_wa[s]);
          chk("wr_data", rf_data, e_wd[s]);
        end
        rf_out_valid = e_vin[s];
        rf_out1      = e_o1[s];
        rf_out2      = e_o2[s];
        if (rst) begin
          for (int i = 1; i <= 16; i++) clear_slot(s + i);
          e_set_rd[s + 1] = 1'b1;
          free   = s + 1;
          m_last = 1;
        end else if (s >= free && (req0 || req1)) begin
          w  = (req0 && req1) ? ((m_last == 1) ? 0 : 1) : (req1 ? 1 : 0);
          o  = w ? op1 : op0;
          a1 = w ? ra1_1 : ra1_0;
          a2 = w ? ra2_1 : ra2_0;
          wa = w ? wa_1 : wa_0;
          wd = w ? wd_1 : wd_0;
          m_last = w;
          t  = s + 1;
          er = (o == 3'b000);
          if (o[2] || o[1]) begin
            e_vb[t] = {o[2], o[1], 1'b0};
            e_rd_chk[t] = 1'b1; e_ra1[t] = a1; e_ra2[t] = a2;
            t = t + 1;
            d = resp_delay;
            if (d < TO) begin
              e_vin[t + d] = 1'b1; e_o1[t + d] = resp_d1; e_o2[t + d] = resp_d2;
              t = t + d + 1;
              e_set_rd[t] = 1'b1;
              e_rd1v[t] = o[2] ? resp_d1 : '0;
              e_rd2v[t] = o[1] ? resp_d2 : '0;
            end else begin
              t = t + TO;
              er = 1'b1;
              e_set_rd[t] = 1'b1; e_rd1v[t] = '0; e_rd2v[t] = '0;
            end
          end
          if (o[0] && !er) begin
            e_vb[t] = {2'b00, wa != '0};
            e_wr_chk[t] = 1'b1; e_wa[t] = wa; e_wd[t] = wd;
            t = t + 1;
          end
          e_done[t] = (w == 1) ? 2'b10 : 2'b01;
          e_err[t]  = er;
          free = t + 1;
        end
      end else begin
        rf_out_valid = 1'b0;
        if (rst) begin
          e_set_rd[s + 1] = 1'b1;
          free   = s + 1;
          m_last = 1;
        end
      end
    end
  end

  // Wait for one completion and pin latency, owner, err and read data to literal values.
  task automatic go(input int who, input int lat, input bit xerr, input logic [DW-1:0] xr1,
                    input logic [DW-1:0] xr2, input int po1, input logic [2:0] pv1,
                    input int po2, input logic [2:0] pv2);
    int t0;
    bit seen;
    t0 = cyc;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (cyc - t0 == po1) chk("probe_vb1", rf_valid_bits, pv1);
      if (cyc - t0 == po2) chk("probe_vb2", rf_valid_bits, pv2);
      if (done0 || done1) begin
        seen = 1;
        chk("lit_owner", {31'b0, done1}, who);
        chk("lit_latency", cyc - t0, lat);
        chk("lit_err", who ? err1 : err0, xerr);
        chk("lit_rdata1", rdata1, xr1);
        chk("lit_rdata2", rdata2, xr2);
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout for requester %0d: got no done expected done within 40 cycles", who);
    end
    @(posedge clk); #1;
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    int ndone, last_d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // read-only, rd1 only
    op0 = 3'b100; ra1_0 = 5; ra2_0 = 7; resp_delay = 0; resp_d1 = 8'h2D; resp_d2 = 8'h77;
    req0 = 1'b1;
    go(0, 3, 0, 8'h2D, 8'h00, 1, 3'b100, 2, 3'b000);

    // write-only, then write to r0
    op1 = 3'b001; wa_1 = 3; wd_1 = 8'hC4; req1 = 1'b1;
    go(1, 2, 0, 8'h2D, 8'h00, 1, 3'b001, -1, 3'b000);
    wa_1 = 0; req1 = 1'b1;
    go(1, 2, 0, 8'h2D, 8'h00, 1, 3'b000, -1, 3'b000);

    // read+write
    op0 = 3'b111; ra1_0 = 1; ra2_0 = 2; wa_0 = 5; wd_0 = 8'h19;
    resp_d1 = 8'h2D; resp_d2 = 8'hEC; req0 = 1'b1;
    go(0, 4, 0, 8'h2D, 8'hEC, 1, 3'b110, 3, 3'b001);

    // timeout, then illegal op
    op0 = 3'b100; ra1_0 = 4; resp_delay = 99; req0 = 1'b1;
    go(0, 6, 1, 8'h00, 8'h00, 1, 3'b100, 5, 3'b000);
    op0 = 3'b000; req0 = 1'b1;
    go(0, 1, 1, 8'h00, 8'h00, 1, 3'b000, -1, 3'b000);

    // both requesting from reset: strict alternation
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    op0 = 3'b110; op1 = 3'b110; ra1_0 = 3; ra2_0 = 4; ra1_1 = 8; ra2_1 = 9;
    resp_delay = 0; resp_d1 = 8'h11; resp_d2 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0; last_d = 0;
    for (int k = 0; k < 60 && ndone < 4; k++) begin
      @(negedge clk);
      if (done0 || done1) begin
        chk("alt_owner", {31'b0, done1}, ndone % 2);
        if (ndone > 0) chk("alt_gap", cyc - last_d, 4);
        last_d = cyc;
        ndone++;
      end
    end
    chk("alt_count", ndone, 4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // reset during WAIT of a read+write from req0
    @(posedge clk); #1;
    op0 = 3'b111; ra1_0 = 9; ra2_0 = 10; wa_0 = 6; wd_0 = 8'h33; resp_delay = 99;
    req0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    op0 = 3'b100; op1 = 3'b100; resp_delay = 0; resp_d1 = 8'h5A; resp_d2 = 8'hA5;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_vb", rf_valid_bits, 3'b000);
    chk("rst_rdata1", rdata1, 8'h00);
    chk("rst_rd_addr1", rf_read_reg1, 5'd0);
    chk("rst_wr_addr", rf_write_reg, 5'd0);
    go(0, 3, 0, 8'h5A, 8'h00, -1, 3'b000, -1, 3'b000);
    go(1, 3, 0, 8'h5A, 8'h00, 1, 3'b100, -1, 3'b000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected end within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
